// File: rtl/i2c_packet_tx_arbiter.sv
// Purpose : round-robin arbiter + serializer framing one byte per grant onto a divided bit clock.
// Latency : grant on the first bit tick after req; frame + gap = (12 + GAP_BITS) * CLK_DIV f_clk cycles.
// Backpress: req is a level held until gnt pulses; requests wait while busy or between ticks.
module i2c_packet_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int CLK_DIV  = 10,
    parameter int GAP_BITS = 2
) (
    input  logic                       f_clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [1:0]                 err_inj,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       clk,
    output logic                       data
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int GAP_CW = $clog2(GAP_BITS + 1);
    localparam int CNT_W  = (GAP_CW > 3) ? GAP_CW : 3;

    typedef enum logic [2:0] {
        IDLE,
        CTRL_MSB,
        CTRL_LSB,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_t;

    // divider
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             tick;

    // frame state
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       sh, sh_nxt;
    logic [1:0]       err_q, err_nxt;
    logic             par_q, par_nxt;
    logic             data_nxt;
    logic             busy_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_nxt;

    // arbiter
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   cand;
    logic [7:0]       pick_byte;

    assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign div_nxt = tick ? '0 : div_cnt + 1'b1;

    // Bit-clock divider: clk is low for the first half of each bit period, high for the second.
    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            clk     <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            clk     <= (div_nxt >= DIV_W'(CLK_DIV / 2));
        end
    end

    // Round-robin pick: first requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!pick_vld && req[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Byte of the picked requester.
    always_comb begin
        pick_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_byte = req_data[8*k +: 8];
            end
        end
    end

    // Next-state and registered-output logic; everything advances only on the bit tick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        err_nxt   = err_q;
        par_nxt   = par_q;
        data_nxt  = data;
        busy_nxt  = busy;
        gnt_nxt   = '0;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        if (tick) begin
            case (state)
                IDLE: begin
                    data_nxt = 1'b1;
                    if (pick_vld) begin
                        gnt_nxt   = NUM_REQ'(1) << pick_idx;
                        owner_nxt = pick_idx;
                        rr_nxt    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        sh_nxt    = pick_byte;
                        err_nxt   = err_inj;
                        par_nxt   = (^pick_byte) ^ (err_inj == 2'b01);
                        busy_nxt  = 1'b1;
                        data_nxt  = ~(err_inj == 2'b10);
                        state_nxt = CTRL_MSB;
                    end
                end
                CTRL_MSB: begin
                    data_nxt  = (err_q == 2'b11);
                    state_nxt = CTRL_LSB;
                end
                CTRL_LSB: begin
                    data_nxt  = sh[7];
                    sh_nxt    = {sh[6:0], 1'b0};
                    cnt_nxt   = '0;
                    state_nxt = DATA;
                end
                DATA: begin
                    if (cnt == CNT_W'(7)) begin
                        data_nxt  = par_q;
                        state_nxt = PARITY;
                    end else begin
                        data_nxt = sh[7];
                        sh_nxt   = {sh[6:0], 1'b0};
                        cnt_nxt  = cnt + 1'b1;
                    end
                end
                PARITY: begin
                    data_nxt  = 1'b1;
                    state_nxt = STOP;
                end
                STOP: begin
                    data_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end
                GAP: begin
                    data_nxt = 1'b1;
                    if (cnt == CNT_W'(GAP_BITS - 1)) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    data_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge f_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            err_q  <= '0;
            par_q  <= 1'b0;
            data   <= 1'b1;
            busy   <= 1'b0;
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sh     <= sh_nxt;
            err_q  <= err_nxt;
            par_q  <= par_nxt;
            data   <= data_nxt;
            busy   <= busy_nxt;
            gnt    <= gnt_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_packet_tx_arbiter.sv
// Purpose : self-checking bench for i2c_packet_tx_arbiter against a frame/arbitration reference model.
// Latency : checks grant latency, frame bits, busy length and frame spacing.
// Backpress: requests are held until granted, then dropped or re-raised with new bytes.
module tb_i2c_packet_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int CLK_DIV  = 10;
    localparam int GAP_BITS = 2;

    logic        f_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [1:0]  err_inj;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        clk;
    logic        data;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_model = 0;
    int cyc = 0;

    i2c_packet_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CLK_DIV (CLK_DIV),
        .GAP_BITS(GAP_BITS)
    ) dut (
        .f_clk   (f_clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .err_inj (err_inj),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .clk     (clk),
        .data    (data)
    );

    always #5 f_clk = ~f_clk;
    always @(posedge f_clk) cyc <= cyc + 1;

    // Bit i is the i-th bit sent on the line.
    function automatic logic [11:0] frame_model(input logic [7:0] b, input logic [1:0] e);
        logic [11:0] f;
        f[0] = (e == 2'b10) ? 1'b0 : 1'b1;
        f[1] = (e == 2'b11) ? 1'b1 : 1'b0;
        for (int k = 0; k < 8; k++) f[2+k] = b[7-k];
        f[10] = (^b) ^ (e == 2'b01);
        f[11] = 1'b1;
        return f;
    endfunction

    function automatic int arb_model(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic wait_gnt(input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound) begin
            @(negedge f_clk);
            cycles++;
            if (gnt != 4'b0000) return;
        end
        cycles = -1;
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        prev = clk;
        ok = 1'b0;
        for (int i = 0; i < 2*CLK_DIV + 2; i++) begin
            @(negedge f_clk);
            if (clk && !prev) begin
                ok = 1'b1;
                return;
            end
            prev = clk;
        end
    endtask

    task automatic capture_frame(output logic [11:0] f, output bit ok);
        f = '0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_rise(ok);
            if (!ok) return;
            f[i] = data;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy) return;
            @(negedge f_clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_data = '0; err_inj = '0;
        repeat (2) @(negedge f_clk);
        n_tests++; if (data !== 1'b1)     begin n_fail++; $display("FAIL reset_data: got %b expected 1", data); end
        n_tests++; if (clk !== 1'b0)      begin n_fail++; $display("FAIL reset_clk: got %b expected 0", clk); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (gnt !== 4'b0000)   begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_tests++; if (owner !== 2'd0)    begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        rst = 1'b0;
        rr_model = 0;
    endtask

    task automatic test_single();
        int lat, busy_cnt, nb;
        logic prev;
        logic [11:0] got;
        rst = 1'b1;
        req = 4'b0001; req_data = 32'h0000_0023; err_inj = 2'b00;
        @(negedge f_clk);
        rst = 1'b0;
        rr_model = 0;
        wait_gnt(50, lat);
        n_tests++;
        if (lat != CLK_DIV) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, CLK_DIV); return; end
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        n_tests++; if (owner !== 2'd0)  begin n_fail++; $display("FAIL single_owner: got %0d expected 0", owner); end
        rr_model = 1;
        req = 4'b0000;
        busy_cnt = busy ? 1 : 0;
        nb = 0; got = '0; prev = clk;
        for (int c = 0; c < 400; c++) begin
            @(negedge f_clk);
            if (!busy) break;
            busy_cnt++;
            if (clk && !prev && nb < 12) begin got[nb] = data; nb++; end
            prev = clk;
        end
        n_tests++; if (nb != 12) begin n_fail++; $display("FAIL single_bits: got %0d bits expected 12", nb); end
        n_tests++; if (got !== 12'b1111_0001_0001) begin n_fail++; $display("FAIL single_frame: got %b expected %b", got, 12'b1111_0001_0001); end
        n_tests++; if (busy_cnt != (12 + GAP_BITS) * CLK_DIV) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, (12 + GAP_BITS) * CLK_DIV); end
    endtask

    task automatic test_arbitration();
        int lat, exp, t_prev;
        logic [3:0] one;
        logic [11:0] got;
        bit ok;
        rst = 1'b1;
        req_data = 32'h0021_0043; err_inj = 2'b00; req = 4'b0101;
        @(negedge f_clk);
        rst = 1'b0;
        rr_model = 0;
        t_prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(200, lat);
            n_tests++;
            if (lat < 0) begin n_fail++; $display("FAIL arb_gnt_timeout: round %0d got none expected grant", g); break; end
            exp = arb_model(req, rr_model);
            one = 4'b0001 << exp;
            n_tests++; if (gnt !== one) begin n_fail++; $display("FAIL arb_gnt: round %0d got %b expected %b", g, gnt, one); end
            n_tests++; if (owner !== 2'(exp)) begin n_fail++; $display("FAIL arb_owner: round %0d got %0d expected %0d", g, owner, exp); end
            if (g > 0) begin
                n_tests++;
                if (cyc - t_prev != (13 + GAP_BITS) * CLK_DIV) begin
                    n_fail++; $display("FAIL arb_spacing: got %0d expected %0d", cyc - t_prev, (13 + GAP_BITS) * CLK_DIV);
                end
            end
            t_prev = cyc;
            rr_model = (exp + 1) % NUM_REQ;
            capture_frame(got, ok);
            n_tests++;
            if (!ok || got !== frame_model(req_data[exp*8 +: 8], 2'b00)) begin
                n_fail++; $display("FAIL arb_frame: round %0d got %b expected %b", g, got, frame_model(req_data[exp*8 +: 8], 2'b00));
            end
        end
        req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_err_inj();
        logic [7:0]  bytes [3] = '{8'h24, 8'h42, 8'h53};
        logic [1:0]  errs  [3] = '{2'b01, 2'b10, 2'b11};
        int lat;
        logic [11:0] got;
        bit ok, bit_ok;
        for (int i = 0; i < 3; i++) begin
            wait_idle();
            req_data[7:0] = bytes[i]; err_inj = errs[i]; req = 4'b0001;
            wait_gnt(400, lat);
            n_tests++;
            if (lat < 0 || gnt !== 4'b0001) begin n_fail++; $display("FAIL err_gnt: case %0d got %b expected 0001", i, gnt); continue; end
            rr_model = 1;
            req = 4'b0000;
            err_inj = 2'($urandom_range(0, 3));
            capture_frame(got, ok);
            n_tests++;
            if (!ok || got !== frame_model(bytes[i], errs[i])) begin
                n_fail++; $display("FAIL err_frame: case %0d got %b expected %b", i, got, frame_model(bytes[i], errs[i]));
            end
            case (errs[i])
                2'b01:   bit_ok = (got[10] === 1'b1);
                2'b10:   bit_ok = (got[0] === 1'b0);
                default: bit_ok = (got[1] === 1'b1);
            endcase
            n_tests++;
            if (!bit_ok) begin n_fail++; $display("FAIL err_bit: case %0d frame %b lacks injected bit for mode %b", i, got, errs[i]); end
        end
        err_inj = 2'b00;
    endtask

    task automatic test_clock();
        logic prev_clk, prev_data;
        int run, bad_run, runs_seen, bad_data, changes;
        bit first;
        wait_idle();
        req_data[31:24] = 8'($urandom); req = 4'b1000;
        prev_clk = clk; prev_data = data;
        run = 0; bad_run = 0; runs_seen = 0; bad_data = 0; changes = 0; first = 1'b1;
        for (int c = 0; c < 250; c++) begin
            @(negedge f_clk);
            if (gnt != 4'b0000) begin req = 4'b0000; rr_model = 0; end
            if (clk != prev_clk) begin
                if (!first) begin
                    runs_seen++;
                    if (run != CLK_DIV / 2) bad_run++;
                end
                first = 1'b0;
                run = 1;
            end else begin
                run++;
            end
            if (data != prev_data) begin
                changes++;
                if (!(prev_clk == 1'b1 && clk == 1'b0)) bad_data++;
            end
            prev_clk = clk; prev_data = data;
        end
        n_tests++; if (bad_run != 0)   begin n_fail++; $display("FAIL clk_halfperiod: got %0d bad runs expected 0", bad_run); end
        n_tests++; if (runs_seen < 15) begin n_fail++; $display("FAIL clk_toggles: got %0d runs expected >=15", runs_seen); end
        n_tests++; if (bad_data != 0)  begin n_fail++; $display("FAIL data_alignment: got %0d misaligned edges expected 0", bad_data); end
        n_tests++; if (changes == 0)   begin n_fail++; $display("FAIL data_activity: got %0d changes expected >0", changes); end
        wait_idle();
    endtask

    task automatic test_random();
        int lat, exp;
        logic [3:0]  one, nb;
        logic [7:0]  eb;
        logic [1:0]  ee;
        logic [11:0] got;
        bit ok;
        wait_idle();
        req = 4'b0000;
        for (int r = 0; r < 10; r++) begin
            if (req == 4'b0000) begin
                nb = 4'($urandom_range(1, 15));
                for (int k = 0; k < 4; k++) if (nb[k]) req_data[k*8 +: 8] = 8'($urandom);
                err_inj = 2'($urandom_range(0, 3));
                req = nb;
            end
            wait_gnt(400, lat);
            n_tests++;
            if (lat < 0) begin n_fail++; $display("FAIL rand_timeout: round %0d got none expected grant", r); break; end
            exp = arb_model(req, rr_model);
            one = 4'b0001 << exp;
            n_tests++; if (gnt !== one) begin n_fail++; $display("FAIL rand_gnt: round %0d got %b expected %b", r, gnt, one); end
            n_tests++; if (owner !== 2'(exp)) begin n_fail++; $display("FAIL rand_owner: round %0d got %0d expected %0d", r, owner, exp); end
            eb = req_data[exp*8 +: 8];
            ee = err_inj;
            rr_model = (exp + 1) % NUM_REQ;
            req[exp] = 1'b0;
            err_inj = 2'($urandom_range(0, 3));
            nb = 4'($urandom) & ~req;
            for (int k = 0; k < 4; k++) if (nb[k]) req_data[k*8 +: 8] = 8'($urandom);
            req = req | nb;
            capture_frame(got, ok);
            n_tests++;
            if (!ok || got !== frame_model(eb, ee)) begin
                n_fail++; $display("FAIL rand_frame: round %0d got %b expected %b", r, got, frame_model(eb, ee));
            end
        end
        req = 4'b0000;
        err_inj = 2'b00;
        wait_idle();
    endtask

    task automatic test_reset_midframe();
        int lat;
        logic [11:0] got;
        bit ok;
        wait_idle();
        req_data[15:8] = 8'h5A; err_inj = 2'b00; req = 4'b0010;
        wait_gnt(400, lat);
        n_tests++;
        if (lat < 0 || gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_first_gnt: got %b expected 0010", gnt); end
        req = 4'b0000;
        for (int i = 0; i < 6; i++) wait_rise(ok);
        repeat (2) @(negedge f_clk);
        rst = 1'b1;
        #1;
        n_tests++; if (data !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_data: got %b expected 1", data); end
        n_tests++; if (clk !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_clk: got %b expected 0", clk); end
        n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
        n_tests++; if (owner !== 2'd0)  begin n_fail++; $display("FAIL mid_rst_owner: got %0d expected 0", owner); end
        req = 4'b0010;
        @(negedge f_clk);
        rst = 1'b0;
        rr_model = 0;
        wait_gnt(50, lat);
        n_tests++;
        if (lat != CLK_DIV || gnt !== 4'b0010) begin
            n_fail++; $display("FAIL mid_regrant: got gnt %b after %0d cycles expected 0010 after %0d", gnt, lat, CLK_DIV);
        end
        req = 4'b0000;
        capture_frame(got, ok);
        n_tests++;
        if (!ok || got !== frame_model(8'h5A, 2'b00)) begin
            n_fail++; $display("FAIL mid_frame: got %b expected %b", got, frame_model(8'h5A, 2'b00));
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_err_inj();
        test_clock();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_packet_tx_arbiter.md
Name: i2c_packet_tx_arbiter

Overview:
- Sequencer and arbiter that drives the custom serial packet link into Top_I2C_interface: outputs `data` and the slow bit clock `clk`, both derived from the fast clock `f_clk`.
- Shares the single link between NUM_REQ byte requesters using round-robin arbitration.
- Frames each byte as: control MSB, control LSB, 8 data bits, even parity, stop.
- Optional error injection per packet, so link-level error detection can be exercised in-system.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CLK_DIV, 10: f_clk cycles per bit period on `clk`; must be even and >= 4.
- GAP_BITS, 2: minimum idle bit periods (data=1) after each stop bit.

Ports:
- f_clk  input  1  fast system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester level request; held high until granted.
- req_data  input  8*NUM_REQ  byte for requester i is at [8i+7:8i]; stable while req[i]=1.
- err_inj  input  2  error injection mode, sampled at grant: 00 none, 01 flip parity, 10 flip control MSB, 11 flip control LSB.
- gnt  output  NUM_REQ  one-hot, one-f_clk-cycle pulse when requester i's byte is latched.
- owner  output  $clog2(NUM_REQ)  index of the last granted requester.
- busy  output  1  high from grant until the last gap bit ends.
- clk  output  1  bit clock to the interface.
- data  output  1  serial line; idles high.

Behaviour:
- Reset values: div_cnt=0, clk=0, data=1, gnt=0, busy=0, owner=0, rr pointer=0, state=IDLE. Reset clears all of these immediately, even mid-frame; no partial frame resumes.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. clk is registered; it is 1 when div_cnt >= CLK_DIV/2, so each period is low then high, 50% duty.
- tick = (div_cnt == CLK_DIV-1). `data` and the state change only on the edge after tick, so data changes as clk falls and is stable across the clk rising edge where the receiver samples.
- States: IDLE -> CTRL_MSB -> CTRL_LSB -> DATA(8 bits) -> PARITY -> STOP -> GAP(GAP_BITS bits) -> IDLE. Each state lasts one bit period, except DATA (8) and GAP (GAP_BITS).
- IDLE: data=1. On tick with any req bit set:
  - Select the first set req at or after the rr pointer, wrapping.
  - In the same edge: pulse gnt[i], set owner=i, set rr pointer=i+1 mod NUM_REQ, latch the byte and err_inj, set busy=1, and drive data for CTRL_MSB.
  - Requests raised between ticks wait for the next tick.
- Bit values:
  - CTRL_MSB = 1 ^ (err==10).
  - CTRL_LSB = 0 ^ (err==11).
  - DATA sent MSB first (D7..D0).
  - PARITY = ^byte ^ (err==01), i.e. even parity over the data bits.
  - STOP = 1.
  - GAP = 1.
- Frame plus gap length: (12 + GAP_BITS) * CLK_DIV f_clk cycles. busy falls on the edge that leaves GAP.
- Back-to-back: if a req is pending on the tick that ends GAP, the FSM passes through IDLE and grants on the next tick. Minimum spacing between frames is therefore GAP_BITS+1 idle bits.
- A requester dropping req before grant is simply skipped. req changes after grant do not affect the frame in flight.
- err_inj is captured only at grant; changes mid-frame are ignored.

Test Plan:
- Single request (CLK_DIV=10, GAP_BITS=2): req[0]=1 with byte 0x23, err=00 -> one gnt[0] pulse at the first tick. data on successive clk rises is 1,0,0,0,1,0,0,0,1,1,1(parity),1(stop). busy is high for 140 f_clk cycles. The interface outputs 0x23.
- Arbitration: req[0] and req[2] held high from reset, bytes 0x43 and 0x21 -> grants in order 0,2,0,2. owner follows the grants. Frames are separated by >= 3 idle bits.
- Parity injection: byte 0x24 with err=01 -> parity bit sent as 1 instead of 0. The interface must flag a parity error and not output 0x24.
- Control injection: byte 0x42 with err=10 -> first bit sent as 0. Byte 0x53 with err=11 -> second bit sent as 1. Both packets are rejected by the interface.
- Reset mid-frame: assert rst during DATA bit 4 -> data=1, clk=0, busy=0, gnt=0 immediately. After release, a pending req[1] with byte 0x5A produces a complete fresh frame starting at CTRL_MSB.
- Clock check: clk period is exactly 10 f_clk cycles (5 low, 5 high). data never toggles except on the cycle where clk falls.
